// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared constants for the round-robin operand arbiter in front of the mux2_4 data path.
package mux2_rr_arbiter_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/mux2_4.sv
// 4-bit 2:1 operand mux: S=0 selects in0, S=1 selects in1.
module mux2_4 (
    output logic [3:0] res,
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    input  logic       S
);

    assign res = S ? in1 : in0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter over two valid/ready channels driving mux2_4 slices into a
// one-deep registered output stage, with saturating per-channel grant counters.
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,   // must be a multiple of 4
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    localparam int                 SLICES  = WIDTH / 4;
    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

    out_state_t       state_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_src_reg;
    logic             last_gnt_reg;
    logic [CNT_W-1:0] gnt_cnt0_reg;
    logic [CNT_W-1:0] gnt_cnt1_reg;

    logic [WIDTH-1:0] mux_res;
    logic             sel_next;
    logic             can_load;
    logic             accept;

    // Contention goes to the channel that did not win last; idle holds the previous grant.
    always_comb begin
        sel_next = last_gnt_reg;
        case ({in1_valid, in0_valid})
            2'b01:   sel_next = CH0;
            2'b10:   sel_next = CH1;
            2'b11:   sel_next = ~last_gnt_reg;
            default: sel_next = last_gnt_reg;
        endcase
    end

    assign sel       = sel_next;
    assign can_load  = (state_reg == ST_EMPTY) | out_ready;
    assign in0_ready = ~rst & can_load & in0_valid & (sel_next == CH0);
    assign in1_ready = ~rst & can_load & in1_valid & (sel_next == CH1);
    assign accept    = in0_ready | in1_ready;

    generate
        for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
            mux2_4 u_mux (
                .res (mux_res[gi*4 +: 4]),
                .in0 (in0_data[gi*4 +: 4]),
                .in1 (in1_data[gi*4 +: 4]),
                .S   (sel_next)
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_EMPTY;
            out_data_reg <= '0;
            out_src_reg  <= CH0;
            last_gnt_reg <= CH1;
            gnt_cnt0_reg <= '0;
            gnt_cnt1_reg <= '0;
        end else if (accept) begin
            // Covers both a load into an empty slot and a simultaneous drain+load.
            state_reg    <= ST_FULL;
            out_data_reg <= mux_res;
            out_src_reg  <= sel_next;
            last_gnt_reg <= sel_next;
            if (sel_next == CH0) begin
                if (gnt_cnt0_reg != CNT_MAX) gnt_cnt0_reg <= gnt_cnt0_reg + CNT_ONE;
            end else begin
                if (gnt_cnt1_reg != CNT_MAX) gnt_cnt1_reg <= gnt_cnt1_reg + CNT_ONE;
            end
        end else if (state_reg == ST_FULL && out_ready) begin
            state_reg <= ST_EMPTY;
        end
    end

    assign out_valid = (state_reg == ST_FULL);
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;
    assign gnt_cnt0  = gnt_cnt0_reg;
    assign gnt_cnt1  = gnt_cnt1_reg;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: a small reference model predicts grants and
// queues accepted operands, which are compared as the output register presents them.
module tb_mux2_rr_arbiter;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    typedef struct {
        logic             src;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in0_valid, in1_valid;
    logic [WIDTH-1:0] in0_data, in1_data;
    logic             in0_ready, in1_ready;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

    int n_cmp = 0;
    int n_err = 0;

    exp_t             sb[$];
    logic             m_full;
    logic             m_last;
    logic [CNT_W-1:0] m_cnt0, m_cnt1;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Hold reset for n cycles with the given valids, then release and check the reset state.
    task automatic reset_dut(input int n, input logic v0, input logic v1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1; in0_valid = v0; in1_valid = v1;
            in0_data = 4'd1; in1_data = 4'd2; out_ready = 1'b1;
            #1;
            check("rst_rdy0", in0_ready, 1'b0);
            check("rst_rdy1", in1_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_full = 1'b0; m_last = 1'b1; m_cnt0 = '0; m_cnt1 = '0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 0);
        check("rst_cnt0", gnt_cnt0, 0);
        check("rst_cnt1", gnt_cnt1, 0);
        $display("reset %0d cycles", n);
    endtask

    task automatic cycle(input logic v0, input logic [WIDTH-1:0] d0,
                         input logic v1, input logic [WIDTH-1:0] d1, input logic ordy);
        logic esel, cl, er0, er1;
        exp_t e;
        @(negedge clk);
        in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1; out_ready = ordy;
        #1;
        case ({v1, v0})
            2'b01:   esel = 1'b0;
            2'b10:   esel = 1'b1;
            2'b11:   esel = ~m_last;
            default: esel = m_last;
        endcase
        cl  = ~m_full | ordy;
        er0 = cl & v0 & ~esel;
        er1 = cl & v1 & esel;
        check("sel", sel, esel);
        check("rdy0", in0_ready, er0);
        check("rdy1", in1_ready, er1);
        check("out_valid", out_valid, m_full);
        if (m_full) begin
            check("sb_size", sb.size(), 1);
            if (sb.size() > 0) begin
                e = sb[0];
                check("out_data", out_data, e.data);
                check("out_src", out_src, e.src);
                if (ordy) begin
                    void'(sb.pop_front());
                    m_full = 1'b0;
                end
            end
        end
        if (er0 | er1) begin
            e.src  = esel;
            e.data = esel ? d1 : d0;
            sb.push_back(e);
            m_full = 1'b1;
            m_last = esel;
            if (!esel && m_cnt0 != '1) m_cnt0 = m_cnt0 + 1'b1;
            if (esel && m_cnt1 != '1) m_cnt1 = m_cnt1 + 1'b1;
        end
        $display("cyc v0=%0b d0=%0d v1=%0b d1=%0d ordy=%0b sel=%0b acc=%0b out_v=%0b out_d=%0d",
                 v0, d0, v1, d1, ordy, sel, er0 | er1, out_valid, out_data);
        @(posedge clk);
        #1;
        check("cnt0", gnt_cnt0, m_cnt0);
        check("cnt1", gnt_cnt1, m_cnt1);
    endtask

    initial begin
        rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
        in0_data = '0; in1_data = '0; out_ready = 1'b0;

        // Reset, then first contention must go to channel 0.
        reset_dut(2, 1'b1, 1'b1);
        cycle(1'b1, 4'd5, 1'b1, 4'd9, 1'b1);
        check("first_src", sb.size() > 0 ? sb[0].src : 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);

        // Alternation: 8,4,8,4.
        reset_dut(1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'd8, 1'b1, 4'd4, 1'b1);
        cycle(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        check("alt_cnt0", gnt_cnt0, 2);
        check("alt_cnt1", gnt_cnt1, 2);

        // Single channel 1.
        reset_dut(1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 1'b1, 4'd3, 1'b1);
        cycle(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        check("single_cnt1", gnt_cnt1, 3);

        // Backpressure: 7 held for 3 stalled cycles, then channel 1 wins.
        reset_dut(1, 1'b0, 1'b0);
        cycle(1'b1, 4'd7, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'd1, 1'b1, 4'd2, 1'b0);
        cycle(1'b1, 4'd1, 1'b1, 4'd2, 1'b1);
        check("bp_next_src", sb.size() > 0 ? sb[0].src : 1'b0, 1'b1);
        cycle(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);

        // Saturation of a 2-bit counter after 5 channel-0 grants.
        reset_dut(1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i + 1), 1'b0, 4'd0, 1'b1);
        cycle(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        check("sat_cnt0", gnt_cnt0, 3);

        // Reset mid-flight discards the held operand.
        reset_dut(1, 1'b0, 1'b0);
        cycle(1'b1, 4'd6, 1'b0, 4'd0, 1'b0);
        check("mid_out_valid", out_valid, 1'b1);
        check("mid_out_data", out_data, 6);
        reset_dut(1, 1'b1, 1'b1);
        cycle(1'b1, 4'd10, 1'b1, 4'd11, 1'b1);
        cycle(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
